mmio_timer_bank: RTL and testbench

MMIO_TIMER_BANK -- requirements
Module: mmio_timer_bank

---
 rtl/mmio_timer_bank.sv | 163 ++++++++++++++++
 tb/tb_mmio_timer_bank.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer_bank.sv
// Bank of NUM_CH down-counting timers with prescalers behind a small MMIO port.
// Per channel: CTRL, LOAD, COUNT, STATUS at addr {ch[2:0], reg[1:0]}.
module mmio_timer_bank #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int PSC_W  = 16
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [4:0]        addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              irq,
  output logic [NUM_CH-1:0] hit_pulse
);

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_LOAD = 2'd1;
  localparam logic [1:0] REG_CNT  = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] per_q, per_d;
  logic [NUM_CH-1:0] ien_q, ien_d;
  logic [NUM_CH-1:0] hit_q, hit_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;
  logic [NUM_CH-1:0] tick, tc, sel, wsel;

  logic [PSC_W-1:0] psc_q [NUM_CH];
  logic [PSC_W-1:0] psc_d [NUM_CH];
  logic [PSC_W-1:0] pre_q [NUM_CH];
  logic [PSC_W-1:0] pre_d [NUM_CH];
  logic [WIDTH-1:0] load_q [NUM_CH];
  logic [WIDTH-1:0] load_d [NUM_CH];
  logic [WIDTH-1:0] cnt_q [NUM_CH];
  logic [WIDTH-1:0] cnt_d [NUM_CH];

  logic [31:0] dout_q, dout_d, rdata;
  logic [2:0]  ch_idx;
  logic [1:0]  reg_sel;
  logic        unused_din;

  assign ch_idx     = addr[4:2];
  assign reg_sel    = addr[1:0];
  assign unused_din = ^din;

  // Out-of-range channel indices match no channel: reads 0, writes dropped.
  always_comb begin
    sel  = '0;
    wsel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i]  = (ch_idx == 3'(i));
      wsel[i] = wr && sel[i];
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel[i]) begin
        case (reg_sel)
          REG_CTRL: begin
            rdata[0]          = en_q[i];
            rdata[1]          = per_q[i];
            rdata[2]          = ien_q[i];
            rdata[16 +: PSC_W] = psc_q[i];
          end
          REG_LOAD: rdata[WIDTH-1:0] = load_q[i];
          REG_CNT:  rdata[WIDTH-1:0] = cnt_q[i];
          REG_STAT: rdata[0]         = hit_q[i];
          default:  rdata            = '0;
        endcase
      end
    end
  end

  always_comb begin
    dout_d  = rd ? rdata : dout_q;
    en_d    = en_q;
    per_d   = per_q;
    ien_d   = ien_q;
    hit_d   = hit_q;
    psc_d   = psc_q;
    pre_d   = pre_q;
    load_d  = load_q;
    cnt_d   = cnt_q;
    pulse_d = '0;
    tick    = '0;
    tc      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tick[i] = en_q[i] && (pre_q[i] >= psc_q[i]);
      if (en_q[i])
        pre_d[i] = tick[i] ? '0 : pre_q[i] + PSC_W'(1);
      // A software COUNT write wins over the tick in the same cycle.
      if (wsel[i] && reg_sel == REG_CNT) begin
        cnt_d[i] = din[WIDTH-1:0];
      end else if (tick[i]) begin
        if (cnt_q[i] != '0)
          cnt_d[i] = cnt_q[i] - WIDTH'(1);
        else
          tc[i] = 1'b1;
      end
      if (tc[i]) begin
        pulse_d[i] = 1'b1;
        hit_d[i]   = 1'b1;
        if (per_q[i])
          cnt_d[i] = load_q[i];
        else
          en_d[i] = 1'b0;
      end
      if (wsel[i] && reg_sel == REG_CTRL) begin
        en_d[i]  = din[0];
        per_d[i] = din[1];
        ien_d[i] = din[2];
        psc_d[i] = din[16 +: PSC_W];
        if (!en_q[i] && din[0])
          pre_d[i] = '0;
      end
      if (wsel[i] && reg_sel == REG_LOAD)
        load_d[i] = din[WIDTH-1:0];
      // A new hit in the same cycle beats the clear.
      if (wsel[i] && reg_sel == REG_STAT && din[0] && !tc[i])
        hit_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      en_q    <= '0;
      per_q   <= '0;
      ien_q   <= '0;
      hit_q   <= '0;
      pulse_q <= '0;
      dout_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        psc_q[i]  <= '0;
        pre_q[i]  <= '0;
        load_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      en_q    <= en_d;
      per_q   <= per_d;
      ien_q   <= ien_d;
      hit_q   <= hit_d;
      pulse_q <= pulse_d;
      dout_q  <= dout_d;
      for (int i = 0; i < NUM_CH; i++) begin
        psc_q[i]  <= psc_d[i];
        pre_q[i]  <= pre_d[i];
        load_q[i] <= load_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign dout      = dout_q;
  assign hit_pulse = pulse_q;
  assign irq       = |(hit_q & ien_q);

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Scoreboard bench for mmio_timer_bank: a 4-channel and a 2-channel instance.
// Reads and hit pulses are queued as expectations and popped by monitors.
module tb_mmio_timer_bank;

  typedef struct {
    logic [31:0] v;
    string       nm;
  } rexp_t;

  typedef struct {
    int ch;
    int cyc;
  } pexp_t;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic        wr_a = 1'b0, rd_a = 1'b0, wr_b = 1'b0, rd_b = 1'b0;
  logic [4:0]  addr_a = '0, addr_b = '0;
  logic [31:0] din_a = '0, din_b = '0;
  logic [31:0] dout_a, dout_b;
  logic        irq_a, irq_b;
  logic [3:0]  hp_a;
  logic [1:0]  hp_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic rdv_a = 1'b0, rdv_b = 1'b0;

  rexp_t qa[$];
  rexp_t qb[$];
  pexp_t pq[$];
  rexp_t re;
  pexp_t pe;

  mmio_timer_bank u_a (
    .clk(clk), .Rst(rst_a), .wr(wr_a), .rd(rd_a), .addr(addr_a),
    .din(din_a), .dout(dout_a), .irq(irq_a), .hit_pulse(hp_a)
  );

  mmio_timer_bank #(.NUM_CH(2)) u_b (
    .clk(clk), .Rst(rst_b), .wr(wr_b), .rd(rd_b), .addr(addr_b),
    .din(din_b), .dout(dout_b), .irq(irq_b), .hit_pulse(hp_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rdv_a <= rd_a && !rst_a;
    rdv_b <= rd_b && !rst_b;
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rdv_a) begin
      if (qa.size() == 0) check("rd_a_unexpected", 32'd1, 32'd0);
      else begin
        re = qa.pop_front();
        check(re.nm, dout_a, re.v);
      end
    end
    if (rdv_b) begin
      if (qb.size() == 0) check("rd_b_unexpected", 32'd1, 32'd0);
      else begin
        re = qb.pop_front();
        check(re.nm, dout_b, re.v);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (hp_a[i] === 1'b1) begin
        if (pq.size() == 0) begin
          check($sformatf("pulse_extra_ch%0d_cyc%0d", i, cyc), 32'd1, 32'd0);
        end else begin
          pe = pq.pop_front();
          check("pulse_ch", 32'(i), 32'(pe.ch));
          check($sformatf("pulse_cyc_ch%0d", i), 32'(cyc), 32'(pe.cyc));
        end
      end
    end
    if (hp_b !== 2'b00)
      check("pulse_b_unexpected", 32'(hp_b), 32'd0);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic a_wr(input logic [4:0] a, input logic [31:0] d);
    addr_a = a; din_a = d; wr_a = 1'b1;
    step(1);
    wr_a = 1'b0;
  endtask

  task automatic a_rd(input logic [4:0] a, input logic [31:0] e,
                      input string nm);
    rexp_t x;
    x.v = e; x.nm = nm;
    qa.push_back(x);
    addr_a = a; rd_a = 1'b1;
    step(1);
    rd_a = 1'b0;
  endtask

  task automatic a_rdwr(input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] old, input string nm);
    rexp_t x;
    x.v = old; x.nm = nm;
    qa.push_back(x);
    addr_a = a; din_a = d; rd_a = 1'b1; wr_a = 1'b1;
    step(1);
    rd_a = 1'b0; wr_a = 1'b0;
  endtask

  task automatic b_wr(input logic [4:0] a, input logic [31:0] d);
    addr_b = a; din_b = d; wr_b = 1'b1;
    step(1);
    wr_b = 1'b0;
  endtask

  task automatic b_rd(input logic [4:0] a, input logic [31:0] e,
                      input string nm);
    rexp_t x;
    x.v = e; x.nm = nm;
    qb.push_back(x);
    addr_b = a; rd_b = 1'b1;
    step(1);
    rd_b = 1'b0;
  endtask

  task automatic exp_pulse(input int ch, input int at);
    pexp_t x;
    x.ch = ch; x.cyc = at;
    pq.push_back(x);
  endtask

  initial begin
    int p;
    step(2);
    rst_a = 1'b0;
    rst_b = 1'b0;
    check("rst_dout_a", dout_a, 32'd0);
    check("rst_irq_a", 32'(irq_a), 32'd0);
    check("rst_hp_a", 32'(hp_a), 32'd0);
    check("rst_dout_b", dout_b, 32'd0);
    a_rd(5'h00, 32'd0, "rst_ctrl0");
    a_rd(5'h02, 32'd0, "rst_cnt0");

    // periodic ch0, psc=0
    a_wr(5'h01, 32'd3);
    a_wr(5'h02, 32'd3);
    a_wr(5'h00, 32'h3);
    p = cyc;
    exp_pulse(0, p + 4);
    exp_pulse(0, p + 8);
    exp_pulse(0, p + 12);
    a_rd(5'h02, 32'd3, "per_cnt_a");
    a_rd(5'h02, 32'd2, "per_cnt_b");
    a_rd(5'h02, 32'd1, "per_cnt_c");
    a_rd(5'h02, 32'd0, "per_cnt_d");
    a_rd(5'h02, 32'd3, "per_cnt_e");
    step(7);
    a_wr(5'h00, 32'h0);
    a_rd(5'h03, 32'd1, "per_hit");
    check("per_irq_off", 32'(irq_a), 32'd0);
    a_wr(5'h03, 32'd0);
    a_rd(5'h03, 32'd1, "stat_w0_noop");
    a_wr(5'h03, 32'd1);
    a_rd(5'h03, 32'd0, "stat_clr");

    // prescaled ch1, psc=4
    a_wr(5'h05, 32'd1);
    a_wr(5'h06, 32'd1);
    a_wr(5'h04, 32'h0004_0003);
    p = cyc;
    exp_pulse(1, p + 10);
    exp_pulse(1, p + 20);
    a_rd(5'h04, 32'h0004_0003, "psc_ctrl");
    step(21);
    a_wr(5'h04, 32'h0);
    a_rdwr(5'h05, 32'h55, 32'd1, "rdwr_old");
    a_rd(5'h05, 32'h55, "rdwr_new");
    a_rd(5'h06, 32'd1, "load_no_cnt");

    // one-shot ch2 with irq
    a_wr(5'h0A, 32'd2);
    a_wr(5'h08, 32'h5);
    p = cyc;
    exp_pulse(2, p + 3);
    step(4);
    a_rd(5'h08, 32'h4, "os_ctrl");
    a_rd(5'h0B, 32'd1, "os_hit");
    a_rd(5'h0A, 32'd0, "os_cnt");
    check("os_irq_on", 32'(irq_a), 32'd1);
    a_wr(5'h0B, 32'd1);
    check("os_irq_off", 32'(irq_a), 32'd0);

    // status clear lands on the terminal-count cycle
    a_wr(5'h0A, 32'd1);
    a_wr(5'h08, 32'h5);
    p = cyc;
    exp_pulse(2, p + 2);
    step(1);
    a_wr(5'h0B, 32'd1);
    a_rd(5'h0B, 32'd1, "clr_vs_tc");
    check("clr_vs_tc_irq", 32'(irq_a), 32'd1);
    a_wr(5'h0B, 32'd1);

    // ctrl write on one-shot terminal count keeps en
    a_wr(5'h0C, 32'h5);
    p = cyc;
    exp_pulse(3, p + 1);
    exp_pulse(3, p + 2);
    a_wr(5'h0C, 32'h5);
    step(2);
    a_rd(5'h0C, 32'h4, "ctrl_vs_tc");
    a_wr(5'h0F, 32'd1);

    // count write on a tick cycle
    a_wr(5'h02, 32'd3);
    a_wr(5'h00, 32'h3);
    p = cyc;
    a_wr(5'h02, 32'd9);
    exp_pulse(0, p + 11);
    a_rd(5'h02, 32'd9, "cnt_vs_tick");
    step(9);
    a_wr(5'h00, 32'h0);
    a_rd(5'h03, 32'd1, "cnt_vs_tick_hit");

    // two-channel instance: out-of-range and mid-count reset
    b_wr(5'h0D, 32'hAB);
    b_rd(5'h0D, 32'd0, "b_ch3_load");
    b_rd(5'h05, 32'd0, "b_ch1_load");
    b_rd(5'h0C, 32'd0, "b_ch3_ctrl");
    b_wr(5'h01, 32'd5);
    b_wr(5'h02, 32'd5);
    b_wr(5'h00, 32'h7);
    step(2);
    b_rd(5'h01, 32'd5, "b_load_pre");
    rst_b = 1'b1;
    addr_b = 5'h00; din_b = 32'h7; wr_b = 1'b1;
    step(1);
    rst_b = 1'b0; wr_b = 1'b0;
    check("b_rst_dout", dout_b, 32'd0);
    check("b_rst_irq", 32'(irq_b), 32'd0);
    b_rd(5'h00, 32'd0, "b_rst_ctrl");
    b_rd(5'h01, 32'd0, "b_rst_load");
    b_rd(5'h02, 32'd0, "b_rst_cnt");
    b_rd(5'h03, 32'd0, "b_rst_stat");
    step(12);

    check("pulse_left", 32'(pq.size()), 32'd0);
    check("rd_a_left", 32'(qa.size()), 32'd0);
    check("rd_b_left", 32'(qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
